// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command path: command field layout, page size
// and the scheduler state type.
package nfc_pkg;
    localparam int CMD_W      = 33;
    localparam int RW_B       = 32;
    localparam int FA_HI      = 31;
    localparam int FA_LO      = 14;
    localparam int MA_HI      = 13;
    localparam int MA_LO      = 7;
    localparam int LEN_HI     = 6;
    localparam int LEN_LO     = 0;
    localparam int PAGE_BYTES = 512;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        FREE = 2'd1,
        BUSY = 2'd2
    } sched_state_t;
endpackage

// File: rtl/nfc_cmd_fifo.sv
// Small synchronous FIFO for host commands; push is ignored when full and pop
// is ignored when empty, so the caller may request either freely.
module nfc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;
    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    ptr_t         wr_ptr_q, rd_ptr_q;
    lvl_t         level_q;
    logic         do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + lvl_t'(1);
                2'b01:   level_q <= level_q - lvl_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/nfc_cmd_sched.sv
// Host-to-NFC command scheduler: queues host commands, splits page-crossing
// transfers in two, and issues one command per NFC completion.
module nfc_cmd_sched
    import nfc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAGE_BITS = $clog2(PAGE_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    host_valid_i,
    output logic                    host_ready_o,
    input  logic [CMD_W-1:0]        host_cmd_i,
    output logic                    host_err_o,
    input  logic                    nfc_done_i,
    output logic [CMD_W-1:0]        nfc_cmd_o,
    output logic                    nfc_cmd_valid_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  q_level_o,
    output sched_state_t            state_o
);
    localparam int FA_W  = FA_HI - FA_LO + 1;
    localparam int MA_W  = MA_HI - MA_LO + 1;
    localparam int LEN_W = LEN_HI - LEN_LO + 1;
    typedef logic [PAGE_BITS:0]        span_t;
    typedef logic [FA_W-PAGE_BITS-1:0] pidx_t;
    typedef logic [LEN_W-1:0]          len_t;
    localparam span_t PAGE_SZ = span_t'(1) << PAGE_BITS;

    logic               fifo_full, fifo_empty, push, pop;
    logic [CMD_W-1:0]   fifo_rdata;
    sched_state_t       state_q, state_d;
    logic [CMD_W-1:0]   rem_q, rem_d, cmd_q, cmd_d;
    logic               rem_valid_q, rem_valid_d, cmd_valid_q, cmd_valid_d, err_q;
    logic               work, can_issue, split;
    logic               h_rw;
    logic [FA_W-1:0]    h_fa;
    logic [MA_W-1:0]    h_ma, rem_ma;
    len_t               h_len, first_len, rem_len;
    span_t              col_plus_len;
    pidx_t              pidx_next;
    logic               host_len_zero;

    assign host_len_zero = (host_cmd_i[LEN_HI:LEN_LO] == '0);
    assign push          = host_valid_i && !fifo_full && !host_len_zero;

    nfc_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (host_cmd_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (q_level_o)
    );

    // Split of the FIFO head, evaluated every cycle and used only on a pop.
    assign h_rw         = fifo_rdata[RW_B];
    assign h_fa         = fifo_rdata[FA_HI:FA_LO];
    assign h_ma         = fifo_rdata[MA_HI:MA_LO];
    assign h_len        = fifo_rdata[LEN_HI:LEN_LO];
    assign col_plus_len = span_t'(h_fa[PAGE_BITS-1:0]) + span_t'(h_len);
    assign split        = (col_plus_len > PAGE_SZ);
    assign first_len    = len_t'(PAGE_SZ - span_t'(h_fa[PAGE_BITS-1:0]));
    assign rem_len      = h_len - first_len;
    assign rem_ma       = h_ma + MA_W'(first_len);
    assign pidx_next    = h_fa[FA_W-1:PAGE_BITS] + pidx_t'(1);

    assign work      = rem_valid_q || !fifo_empty;
    assign can_issue = (state_q == FREE) || ((state_q == BUSY) && nfc_done_i);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        rem_valid_d = rem_valid_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            BOOT:    if (nfc_done_i) state_d = FREE;
            FREE:    if (work) state_d = BUSY;
            BUSY:    if (nfc_done_i && !work) state_d = FREE;
            default: state_d = BOOT;
        endcase
        if (can_issue && work) begin
            cmd_valid_d = 1'b1;
            if (rem_valid_q) begin
                cmd_d       = rem_q;
                rem_valid_d = 1'b0;
            end else begin
                pop = 1'b1;
                if (split) begin
                    cmd_d       = {h_rw, h_fa, h_ma, first_len};
                    rem_d       = {h_rw, pidx_next, {PAGE_BITS{1'b0}}, rem_ma, rem_len};
                    rem_valid_d = 1'b1;
                end else begin
                    cmd_d = fifo_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            rem_q       <= '0;
            rem_valid_q <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            rem_valid_q <= rem_valid_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= host_valid_i && !fifo_full && host_len_zero;
        end
    end

    assign host_ready_o    = !fifo_full;
    assign host_err_o      = err_q;
    assign nfc_cmd_o       = cmd_q;
    assign nfc_cmd_valid_o = cmd_valid_q;
    assign busy_o          = (state_q == BUSY);
    assign state_o         = state_q;
endmodule

// File: tb/tb_nfc_cmd_sched.sv
// Bench for nfc_cmd_sched: directed scenarios then random traffic, all checked
// cycle by cycle against a queue-based model of the scheduling rules.
module tb_nfc_cmd_sched;
    import nfc_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             host_valid = 1'b0;
    logic             host_ready;
    logic [CMD_W-1:0] host_cmd = '0;
    logic             host_err;
    logic             nfc_done = 1'b0;
    logic [CMD_W-1:0] nfc_cmd;
    logic             nfc_cmd_valid;
    logic             busy;
    logic [LW-1:0]    q_level;
    sched_state_t     state;

    nfc_cmd_sched #(.DEPTH(DEPTH), .PAGE_BITS(9)) dut (
        .clk             (clk),
        .rst             (rst),
        .host_valid_i    (host_valid),
        .host_ready_o    (host_ready),
        .host_cmd_i      (host_cmd),
        .host_err_o      (host_err),
        .nfc_done_i      (nfc_done),
        .nfc_cmd_o       (nfc_cmd),
        .nfc_cmd_valid_o (nfc_cmd_valid),
        .busy_o          (busy),
        .q_level_o       (q_level),
        .state_o         (state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input int rw, input int f, input int m, input int l);
        return {1'(rw), 18'(f), 7'(m), 7'(l)};
    endfunction

    // reference model: NFC started / executing, stored commands, pending remainder
    bit               m_started, m_busy, m_valid, m_err;
    logic [CMD_W-1:0] m_cmd;
    logic [CMD_W-1:0] m_fifo[$];
    logic [CMD_W-1:0] m_rem[$];
    logic [CMD_W-1:0] exp_q[$];

    task automatic model_clear();
        m_started = 0; m_busy = 0; m_valid = 0; m_err = 0; m_cmd = '0;
        m_fifo.delete(); m_rem.delete(); exp_q.delete();
    endtask

    task automatic model_take();
        logic [CMD_W-1:0] c;
        int rw, f, m, l, col, first;
        c = m_fifo.pop_front();
        rw = int'(c[32]); f = int'(c[31:14]); m = int'(c[13:7]); l = int'(c[6:0]);
        col = f % 512;
        if (col + l <= 512) begin
            m_cmd = c;
        end else begin
            first = 512 - col;
            m_cmd = mk(rw, f, m, first);
            m_rem.push_back(mk(rw, (((f / 512) + 1) % 512) * 512, (m + first) % 128, l - first));
        end
    endtask

    task automatic model_edge(input bit hv, input logic [CMD_W-1:0] hc, input bit done);
        bit accept;
        accept  = hv && (m_fifo.size() < DEPTH);
        m_valid = 0;
        m_err   = accept && (hc[6:0] == 0);
        if (!m_started) begin
            if (done) m_started = 1;
        end else if (!m_busy || done) begin
            if (m_rem.size() > 0) begin
                m_cmd = m_rem.pop_front();
                m_valid = 1;
            end else if (m_fifo.size() > 0) begin
                model_take();
                m_valid = 1;
            end
            m_busy = m_valid;
            if (m_valid) exp_q.push_back(m_cmd);
        end
        if (accept && hc[6:0] != 0) m_fifo.push_back(hc);
    endtask

    task automatic compare_outputs();
        sched_state_t exp_st;
        exp_st = !m_started ? BOOT : (m_busy ? BUSY : FREE);
        check("host_ready", host_ready, m_fifo.size() < DEPTH);
        check("q_level", q_level, m_fifo.size());
        check("busy", busy, m_busy);
        check("state", state, exp_st);
        check("nfc_cmd_valid", nfc_cmd_valid, m_valid);
        check("host_err", host_err, m_err);
        check("nfc_cmd", nfc_cmd, m_cmd);
        if (nfc_cmd_valid)
            check("sb_cmd", nfc_cmd, (exp_q.size() > 0) ? exp_q.pop_front() : '1);
    endtask

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic step(input bit hv, input logic [CMD_W-1:0] hc, input bit done);
        host_valid = hv; host_cmd = hc; nfc_done = done;
        @(posedge clk);
        model_edge(hv, hc, done);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit done);
        for (int i = 0; i < n; i++) step(0, '0, done);
    endtask

    task automatic do_reset();
        host_valid = 0; nfc_done = 0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("rst_ready", host_ready, 1);
        check("rst_level", q_level, 0);
        check("rst_cmd", nfc_cmd, 0);
        check("rst_valid", nfc_cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", host_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [CMD_W-1:0] rc;
        int f;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // 1: boot then simple issue
        idle(2, 0);
        step(0, '0, 1);
        step(1, mk(0, 'h10, 5, 16), 0);
        step(0, '0, 0);
        check("t1_cmd", nfc_cmd, mk(0, 'h10, 5, 16));
        check("t1_busy", busy, 1);
        idle(1, 1);

        // 2: page-crossing split
        step(1, mk(1, 'h1F8, 0, 20), 0);
        step(0, '0, 0);
        check("t2_first", nfc_cmd, mk(1, 'h1F8, 0, 8));
        idle(2, 0);
        step(0, '0, 1);
        check("t2_rem", nfc_cmd, mk(1, 'h200, 8, 12));
        idle(1, 1);

        // 3: fill FIFO while NFC busy
        step(1, mk(0, 0, 0, 1), 0);
        for (int i = 0; i < 4; i++) step(1, mk(0, 'h40 * i, i, 3 + i), 0);
        check("t3_level", q_level, 4);
        check("t3_ready", host_ready, 0);
        step(1, mk(1, 'h3000, 7, 9), 0);
        step(1, mk(1, 'h3000, 7, 9), 1);
        check("t3_after_pop", q_level, 3);
        step(1, mk(1, 'h3000, 7, 9), 0);
        check("t3_accepted", q_level, 4);
        for (int i = 0; i < 6; i++) step(0, '0, 1);

        // 4: zero-length command dropped
        step(1, mk(0, 5, 0, 0), 0);
        check("t4_err", host_err, 1);
        check("t4_level", q_level, 0);
        idle(2, 0);

        // 5: split with m_addr wrap
        step(1, mk(0, 'h1F4, 125, 20), 0);
        step(0, '0, 0);
        check("t5_first", nfc_cmd, mk(0, 'h1F4, 125, 12));
        step(0, '0, 1);
        check("t5_rem", nfc_cmd, mk(0, 'h200, 9, 8));
        idle(1, 1);

        // 6: reset while busy with two queued
        step(1, mk(0, 'h100, 1, 4), 0);
        step(1, mk(0, 'h200, 2, 4), 0);
        step(1, mk(0, 'h300, 3, 4), 0);
        check("t6_level", q_level, 2);
        do_reset();
        idle(4, 0);
        check("t6_no_issue", busy, 0);
        step(0, '0, 1);

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                f  = $urandom_range(0, 3) == 0 ? ($urandom & 32'h3FE00) | $urandom_range(400, 511)
                                               : int'($urandom & 32'h3FFFF);
                rc = mk($urandom_range(0, 1), f, $urandom_range(0, 127),
                        $urandom_range(0, 15) == 0 ? 0 : $urandom_range(1, 127));
                step($urandom_range(0, 1), rc,
                     m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
            end
        end
        idle(12, 1);
        check("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
